key_scan_low: RTL and testbench
===============================

// Module: key_scan_low
// PURPOSE
//  Front-end for the 4-to-2 active-low encoder. Takes four raw active-low pushbuttons.
//  Synchronises and debounces each button, then locks onto exactly one key.
//  Drives an active-low one-hot vector w_n[3:0] straight into the encoder's w input.
//  Also emits a key-valid level and a one-cycle press strobe for downstream logic.
// PARAMETERS
//  DB_CNT      16  consecutive stable synced cycles before a debounced bit flips (>=2)
//  REPEAT_DLY  64  cycles a key must stay held before the first auto-repeat (AUTO_REPEAT_EN)
//  REPEAT_RATE 16  cycles between auto-repeat strobes after the first (AUTO_REPEAT_EN)
// PORTS
//  clk        in   1  rising-edge clock
//  rst_n      in   1  reset; one clock; reset is asynchronous and active-low
//  btn_n      in   4  raw pushbuttons; 0 = pressed; asynchronous to clk
//  w_n        out  4  to encoder w; 1111 = no key, else exactly one bit low
//  key_valid  out  1  1 while a key is locked (w_n != 1111)
//  key_press  out  1  one-cycle strobe on lock (and on each repeat if enabled)
// BEHAVIOUR
//  Reset values: sync FFs = 1111, debounced = 1111, counters = 0, state = IDLE.
//  Reset outputs: w_n = 1111, key_valid = 0, key_press = 0.
//  Reset mid-press returns all state and outputs to reset values immediately.
//  After release, the pressed key is re-debounced from scratch.
//  Sync: 2-FF synchroniser per bit.
//  Debounce, per bit:
//   - cnt clears whenever sync == deb.
//   - Otherwise cnt increments.
//   - When sync != deb and cnt == DB_CNT-1, deb <= sync and cnt <= 0 on that edge.
//   - Any glitch shorter than DB_CNT synced cycles never reaches deb.
//  FSM (2 states):
//   IDLE: w_n = 1111, key_valid = 0.
//    - If any deb bit is 0, lock the lowest-index low bit as idx.
//    - On the same edge: w_n <= ~(1<<idx), key_valid <= 1, key_press <= 1 for one cycle.
//    - Go to HELD.
//   HELD: w_n is held.
//    - Other keys pressed or released are ignored.
//    - When deb[idx] returns to 1: w_n <= 1111, key_valid <= 0, go to IDLE.
//  Latency:
//   - A btn_n edge held stable changes w_n on the (DB_CNT+3)-th rising clk edge after it.
//   - key_press asserts in the same cycle w_n changes.
//  Simultaneous presses: lowest index wins.
//  Release with another key still held:
//   - w_n = 1111 for exactly one cycle.
//   - Then the next lowest held key locks and key_press pulses.
//  All outputs are registered; no combinational path from btn_n to any output.
// CONFIGURATION
//  AUTO_REPEAT_EN defined:
//   - HELD runs a repeat counter from the lock edge.
//   - key_press pulses REPEAT_DLY cycles after the lock pulse, then every REPEAT_RATE cycles.
//   - The repeat counter clears on leaving HELD.
//  AUTO_REPEAT_EN undefined:
//   - Exactly one key_press per lock.
//   - No repeat counter logic is synthesised.
// STRUCTURE
//  Shared header key_scan_defs.vh holds:
//   - N_KEYS = 4, NO_KEY = 4'b1111.
//   - State codes ST_IDLE = 1'b0, ST_HELD = 1'b1.
//   - Counter widths as clog2 expressions.
//  Sub-module key_debounce (one bit: 2-FF sync plus debounce counter).
//   - Generate N_KEYS instances; output deb.
//  Top level holds the FSM, the lowest-index priority pick, and the optional repeat counter.
// TESTING  (DB_CNT=4, REPEAT_DLY=8, REPEAT_RATE=4)
//  1 btn_n 1111->1011 held -> w_n=1011 on edge 7, key_valid=1, key_press 1 cycle.
//    Release -> w_n=1111 on edge 7 after release.
//  2 btn_n[0] low for 3 cycles then high -> w_n stays 1111, key_press never asserts.
//  3 btn_n 1111->0110 in one cycle -> w_n=1110.
//    btn_n[3] release while [0] held -> no change.
//  4 Hold key 1 and key 2, release key 1 -> w_n 1101 -> 1111 (1 cycle) -> 1011.
//    Second key_press on 1011.
//  5 rst_n low mid-HELD asynchronously -> w_n=1111, key_valid=0 with no clk edge.
//    Key still held after rst_n rises -> relocks after DB_CNT+3 edges.
//  6 AUTO_REPEAT_EN, hold key 3 for 30 cycles -> w_n=0111.
//    key_press at lock, lock+8, lock+12, lock+16, ...
//    Undefined -> a single pulse only.

Source files
------------

// File: rtl/key_scan_low_pkg.sv
// Shared constants, state codes and key-pick helpers for the key_scan_low front-end.
// Counter widths are derived with $clog2 inside the modules that own the counters.
package key_scan_low_pkg;

    localparam int N_KEYS = 4;
    localparam logic [N_KEYS-1:0] NO_KEY = 4'b1111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_t;

    // Index of the lowest active-low (0) bit; only meaningful when v != NO_KEY.
    function automatic logic [1:0] lowest_low(input logic [N_KEYS-1:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (!v[i]) begin
                r = 2'(i);
            end
        end
        return r;
    endfunction

    // Active-low one-hot vector with only bit idx driven low.
    function automatic logic [N_KEYS-1:0] onehot_low(input logic [1:0] idx);
        logic [N_KEYS-1:0] r;
        r = NO_KEY;
        r[idx] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/key_scan_low_debounce.sv
// One pushbutton bit: 2-FF synchroniser followed by a stability counter.
// deb only follows the synced input once it has differed for DB_CNT consecutive cycles.
module key_scan_low_debounce #(
    parameter int DB_CNT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_n,
    output logic deb
);

    localparam int CW = $clog2(DB_CNT);

    logic             meta;
    logic             sync;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            sync <= 1'b1;
            deb  <= 1'b1;
            cnt  <= '0;
        end else begin
            meta <= raw_n;
            sync <= meta;
            if (sync == deb) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CNT - 1)) begin
                deb <= sync;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/key_scan_low.sv
// Debounced 4-key scanner that locks one key and drives an active-low one-hot w_n.
// Optional auto-repeat on key_press is enabled by defining AUTO_REPEAT_EN.
module key_scan_low
    import key_scan_low_pkg::*;
#(
    parameter int DB_CNT      = 16,
    parameter int REPEAT_DLY  = 64,
    parameter int REPEAT_RATE = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] btn_n,
    output logic [N_KEYS-1:0] w_n,
    output logic              key_valid,
    output logic              key_press
);

    if (DB_CNT < 2) begin : g_bad_db
        $error("DB_CNT must be at least 2");
    end
    if (REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DLY) begin : g_bad_rate
        $error("REPEAT_RATE must be in 1..REPEAT_DLY");
    end

    logic [N_KEYS-1:0] deb;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_deb
        key_scan_low_debounce #(
            .DB_CNT (DB_CNT)
        ) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .raw_n (btn_n[k]),
            .deb   (deb[k])
        );
    end

    state_t            state;
    state_t            state_nx;
    logic [1:0]        idx;
    logic [1:0]        idx_nx;
    logic [N_KEYS-1:0] w_nx;
    logic              valid_nx;
    logic              press_nx;

`ifdef AUTO_REPEAT_EN
    // Counts held cycles up to REPEAT_DLY-1, then reloads so later hits are REPEAT_RATE apart.
    localparam int RW = $clog2(REPEAT_DLY + 1);
    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_nx;
`endif

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        w_nx     = w_n;
        valid_nx = key_valid;
        press_nx = 1'b0;
`ifdef AUTO_REPEAT_EN
        rep_nx   = rep_cnt;
`endif
        case (state)
            ST_IDLE: begin
                w_nx     = NO_KEY;
                valid_nx = 1'b0;
                if (deb != NO_KEY) begin
                    idx_nx   = lowest_low(deb);
                    w_nx     = onehot_low(lowest_low(deb));
                    valid_nx = 1'b1;
                    press_nx = 1'b1;
                    state_nx = ST_HELD;
`ifdef AUTO_REPEAT_EN
                    rep_nx   = '0;
`endif
                end
            end
            ST_HELD: begin
                // Only the locked key matters here; release wins over a repeat hit.
                if (deb[idx]) begin
                    w_nx     = NO_KEY;
                    valid_nx = 1'b0;
                    state_nx = ST_IDLE;
`ifdef AUTO_REPEAT_EN
                    rep_nx   = '0;
`endif
                end
`ifdef AUTO_REPEAT_EN
                else if (rep_cnt == RW'(REPEAT_DLY - 1)) begin
                    press_nx = 1'b1;
                    rep_nx   = RW'(REPEAT_DLY - REPEAT_RATE);
                end else begin
                    rep_nx   = rep_cnt + RW'(1);
                end
`endif
            end
            default: begin
                w_nx     = NO_KEY;
                valid_nx = 1'b0;
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= 2'd0;
            w_n       <= NO_KEY;
            key_valid <= 1'b0;
            key_press <= 1'b0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            w_n       <= w_nx;
            key_valid <= valid_nx;
            key_press <= press_nx;
        end
    end

`ifdef AUTO_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_nx;
        end
    end
`endif

endmodule

// File: tb/tb_key_scan_low.sv
// Directed bench for key_scan_low with a cycle model of the debounce/lock/repeat rules.
// Build with or without AUTO_REPEAT_EN; expectations follow the same macro.
module tb_key_scan_low;

    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RR = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn_n = 4'b1111;
    logic [3:0] w_n;
    logic       key_valid;
    logic       key_press;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / DUT ----------------
    always #5 clk = ~clk;

    key_scan_low #(
        .DB_CNT      (DB),
        .REPEAT_DLY  (RD),
        .REPEAT_RATE (RR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_n     (btn_n),
        .w_n       (w_n),
        .key_valid (key_valid),
        .key_press (key_press)
    );

    // ---------------- behavioural model ----------------
    // hist[0] is the btn_n sample from the previous edge; the synced value seen at
    // edge t is the sample from edge t-2, so hist[1..DB] is the debounce window.
    logic [3:0] hist [0:DB];
    logic [3:0] deb_m;
    int         idx_m;
    int         age_m;
    logic [3:0] w_m;
    logic       v_m;
    logic       p_m;
    logic [5:0] exp_q [$];

    task automatic model_reset();
        for (int j = 0; j <= DB; j++) hist[j] = 4'b1111;
        deb_m = 4'b1111;
        idx_m = -1;
        age_m = 0;
        w_m   = 4'b1111;
        v_m   = 1'b0;
        p_m   = 1'b0;
    endtask

    task automatic model_step();
        int  pick;
        logic same;
        p_m = 1'b0;
        if (idx_m < 0) begin
            w_m  = 4'b1111;
            v_m  = 1'b0;
            pick = -1;
            for (int k = 0; k < 4; k++) if (pick < 0 && !deb_m[k]) pick = k;
            if (pick >= 0) begin
                idx_m       = pick;
                age_m       = 0;
                w_m         = 4'b1111;
                w_m[pick]   = 1'b0;
                v_m         = 1'b1;
                p_m         = 1'b1;
            end
        end else if (deb_m[idx_m]) begin
            idx_m = -1;
            w_m   = 4'b1111;
            v_m   = 1'b0;
        end else begin
            age_m++;
`ifdef AUTO_REPEAT_EN
            if (age_m == RD || (age_m > RD && (age_m - RD) % RR == 0)) p_m = 1'b1;
`endif
        end
        for (int k = 0; k < 4; k++) begin
            same = 1'b1;
            for (int j = 1; j <= DB; j++) if (hist[j][k] != hist[1][k]) same = 1'b0;
            if (same && hist[1][k] != deb_m[k]) deb_m[k] = hist[1][k];
        end
        for (int j = DB; j >= 1; j--) hist[j] = hist[j-1];
        hist[0] = btn_n;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
                exp_q.delete();
                exp_q.push_back({4'b1111, 1'b0, 1'b0});
            end else begin
                model_step();
                exp_q.push_back({w_m, v_m, p_m});
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    initial begin
        logic [5:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({w_n, key_valid, key_press} !== e) begin
                    errors++;
                    $display("FAIL model_cmp t=%0t got w_n=%b valid=%b press=%b want w_n=%b valid=%b press=%b",
                             $time, w_n, key_valid, key_press, e[5:2], e[1], e[0]);
                end
            end
        end
    end

    // ---------------- driver / literal check tasks ----------------
    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v);
        @(negedge clk);
        btn_n = v;
    endtask

    task automatic chk(input string name, input logic [3:0] ew, input logic ev, input logic ep);
        checks++;
        if (w_n !== ew || key_valid !== ev || key_press !== ep) begin
            errors++;
            $display("FAIL %s got w_n=%b valid=%b press=%b want w_n=%b valid=%b press=%b",
                     name, w_n, key_valid, key_press, ew, ev, ep);
        end
    endtask

    task automatic chk_w(input string name, input logic [3:0] ew, input logic ev);
        checks++;
        if (w_n !== ew || key_valid !== ev) begin
            errors++;
            $display("FAIL %s got w_n=%b valid=%b want w_n=%b valid=%b", name, w_n, key_valid, ew, ev);
        end
    endtask

    task automatic chk_val(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic count_press(input int n, output int presses);
        presses = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (key_press) presses++;
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int         np;
        logic [31:0] mask;
        logic [31:0] exp_mask;

        rst_n = 1'b0;
        btn_n = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_held", 4'b1111, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_edges(2);
        chk("reset_out", 4'b1111, 1'b0, 1'b0);

        // single key 2, lock on 7th edge, release on 7th edge
        drive(4'b1011);
        wait_edges(6);
        chk("t1_pre", 4'b1111, 1'b0, 1'b0);
        wait_edges(1);
        chk("t1_lock", 4'b1011, 1'b1, 1'b1);
        wait_edges(1);
        chk("t1_held", 4'b1011, 1'b1, 1'b0);
        wait_edges(4);
        drive(4'b1111);
        wait_edges(6);
        chk_w("t1_rel_pre", 4'b1011, 1'b1);
        wait_edges(1);
        chk_w("t1_rel", 4'b1111, 1'b0);

        // 3-cycle glitch on key 0 never reaches the output
        drive(4'b1110);
        repeat (3) @(posedge clk);
        drive(4'b1111);
        count_press(15, np);
        chk_val("t2_glitch_press", 32'(np), 32'd0);
        chk_w("t2_glitch_w", 4'b1111, 1'b0);

        // simultaneous keys 0 and 3; release of 3 ignored
        drive(4'b0110);
        wait_edges(7);
        chk("t3_lock", 4'b1110, 1'b1, 1'b1);
        drive(4'b1110);
        count_press(12, np);
`ifdef AUTO_REPEAT_EN
        chk_val("t3_ign_press", 32'(np), 32'd2);
`else
        chk_val("t3_ign_press", 32'(np), 32'd0);
`endif
        chk_w("t3_ign_w", 4'b1110, 1'b1);
        drive(4'b1111);
        wait_edges(7);
        chk_w("t3_rel", 4'b1111, 1'b0);

        // keys 1+2 held, release 1 -> one idle cycle then key 2
        drive(4'b1001);
        wait_edges(7);
        chk("t4_lock", 4'b1101, 1'b1, 1'b1);
        drive(4'b1011);
        wait_edges(6);
        chk_w("t4_pre", 4'b1101, 1'b1);
        wait_edges(1);
        chk("t4_gap", 4'b1111, 1'b0, 1'b0);
        wait_edges(1);
        chk("t4_relock", 4'b1011, 1'b1, 1'b1);
        wait_edges(1);
        chk_w("t4_held", 4'b1011, 1'b1);
        drive(4'b1111);
        wait_edges(8);
        chk_w("t4_rel", 4'b1111, 1'b0);

        // asynchronous reset while held, then relock from scratch
        drive(4'b1011);
        wait_edges(9);
        chk_w("t5_held", 4'b1011, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async", 4'b1111, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_edges(6);
        chk_w("t5_pre", 4'b1111, 1'b0);
        wait_edges(1);
        chk("t5_relock", 4'b1011, 1'b1, 1'b1);
        drive(4'b1111);
        wait_edges(8);
        chk_w("t5_rel", 4'b1111, 1'b0);

        // key 3 held 30 cycles: press pattern relative to the lock edge
        drive(4'b0111);
        wait_edges(7);
        chk("t6_lock", 4'b0111, 1'b1, 1'b1);
        mask = 32'h1;
        for (int off = 1; off <= 30; off++) begin
            wait_edges(1);
            if (key_press) mask[off] = 1'b1;
        end
`ifdef AUTO_REPEAT_EN
        exp_mask = 32'h1111_1101;
`else
        exp_mask = 32'h0000_0001;
`endif
        chk_val("t6_press_mask", mask, exp_mask);
        chk_w("t6_held", 4'b0111, 1'b1);
        drive(4'b1111);
        wait_edges(8);
        chk_w("t6_rel", 4'b1111, 1'b0);

        wait_edges(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
